// File: rtl/display_scan_ctrl.sv
`timescale 1ns/1ps
// Three-digit multiplexed 7-segment driver: double-dabble binary-to-BCD converter plus a free-running digit scanner.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros on the hundreds and tens digits.
//
// state  | meaning
// IDLE   | waiting for load; ready=1
// SHIFT  | one double-dabble iteration per cycle, 10 in total
// COMMIT | copy BCD digits and overflow flag into display registers
module display_scan_ctrl #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [9:0] value,
    output logic       ready,
    output logic [6:0] seg,
    output logic [2:0] x
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t        state, state_nxt;
    logic          capture, do_shift, do_commit;
    logic [21:0]   dd, dd_adj, dd_step;
    logic [3:0]    iter;
    logic          ovf_cap;
    logic [3:0]    disp_h, disp_t, disp_u;
    logic          disp_ovf;
    logic [PW-1:0] pre_cnt;
    logic          pre_wrap;
    logic [1:0]    digit_idx, scan_idx;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic [2:0]    x_nxt;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (iter == 4'd9) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        capture   = (state == IDLE) && load;
        do_shift  = (state == SHIFT);
        do_commit = (state == COMMIT);
    end

    // Layout of dd: [21:18] hundreds, [17:14] tens, [13:10] units, [9:0] binary still to shift in.
    always_comb begin
        dd_adj = dd;
        for (int i = 0; i < 3; i++) begin
            if (dd[10+4*i +: 4] >= 4'd5)
                dd_adj[10+4*i +: 4] = dd[10+4*i +: 4] + 4'd3;
        end
        dd_step = {dd_adj[20:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dd       <= '0;
            iter     <= '0;
            ovf_cap  <= 1'b0;
            disp_h   <= '0;
            disp_t   <= '0;
            disp_u   <= '0;
            disp_ovf <= 1'b0;
        end else begin
            if (capture) begin
                dd      <= {12'd0, value};
                iter    <= '0;
                ovf_cap <= (value > 10'd999);
            end else if (do_shift) begin
                dd   <= dd_step;
                iter <= iter + 4'd1;
            end
            if (do_commit) begin
                disp_h   <= dd[21:18];
                disp_t   <= dd[17:14];
                disp_u   <= dd[13:10];
                disp_ovf <= ovf_cap;
            end
        end
    end

    assign pre_wrap = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            digit_idx <= 2'd0;
        end else begin
            pre_cnt <= pre_wrap ? '0 : pre_cnt + PW'(1);
            if (digit_idx == 2'd3)
                digit_idx <= 2'd0;
            else if (pre_wrap)
                digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end
    end

    // An illegal index is displayed as the units slot so x never shows zero or two enables.
    assign scan_idx = (digit_idx == 2'd3) ? 2'd0 : digit_idx;

    always_comb begin
        digit = disp_u;
        blank = 1'b0;
        x_nxt = 3'b110;
        case (scan_idx)
            2'd1: begin
                digit = disp_t;
                blank = LZB && (disp_h == 4'd0) && (disp_t == 4'd0);
                x_nxt = 3'b101;
            end
            2'd2: begin
                digit = disp_h;
                blank = LZB && (disp_h == 4'd0);
                x_nxt = 3'b011;
            end
            default: begin
                digit = disp_u;
                blank = 1'b0;
                x_nxt = 3'b110;
            end
        endcase
        if (disp_ovf)   seg_nxt = SEG_DASH;
        else if (blank) seg_nxt = SEG_BLANK;
        else            seg_nxt = seg_encode(digit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            x   <= 3'b111;
        end else begin
            seg <= seg_nxt;
            x   <= x_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for display_scan_ctrl: cycle-level reference model plus directed literal checks and random loads/resets.
module tb_display_scan_ctrl;

    localparam int P = 4;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [9:0] value;
    logic       ready;
    logic [6:0] seg;
    logic [2:0] x;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // reference model state
    int         m_n    = 0;
    int         m_busy = 0;
    int         m_pend = 0;
    int         m_disp = 0;
    bit         m_ready = 1;
    logic [6:0] m_seg = 7'h7f;
    logic [2:0] m_x   = 3'b111;

    display_scan_ctrl #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .ready (ready),
        .seg   (seg),
        .x     (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] expect_seg(input int v, input int slot);
        int h, t, u;
        if (v > 999) return 7'b0111111;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 2 && h == 0) return 7'b1111111;
        if (slot == 1 && h == 0 && t == 0) return 7'b1111111;
`endif
        if (slot == 2) return enc(h);
        if (slot == 1) return enc(t);
        return enc(u);
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: scan slot follows from edges since reset; a conversion is a busy countdown of 11 edges.
    always @(posedge clk) begin
        int slot;
        if (!rst_n) begin
            m_n = 0; m_busy = 0; m_disp = 0;
            m_ready = 1; m_seg = 7'h7f; m_x = 3'b111;
        end else begin
            m_n++;
            slot  = ((m_n - 1) / P) % 3;
            m_x   = 3'b111;
            m_x[slot] = 1'b0;
            m_seg = expect_seg(m_disp, slot);
            if (m_busy == 0) begin
                if (load) begin
                    m_busy = 11;
                    m_pend = int'(value);
                end
            end else begin
                m_busy--;
                if (m_busy == 0) m_disp = m_pend;
            end
            m_ready = (m_busy == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", {6'd0, ready}, {6'd0, m_ready});
            check("model_x", {4'd0, x}, {4'd0, m_x});
            check("model_seg", seg, m_seg);
        end
    end

    task automatic wait_x(input logic [2:0] target);
        for (int i = 0; i < 3 * P + 2; i++) begin
            @(posedge clk); #1;
            if (x == target) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_x: x=%b never reached %b", x, target);
    endtask

    task automatic do_load(input int v);
        value = 10'(v);
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
    endtask

    logic [6:0] lead_zero;

    initial begin
        int low;
        int r;
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero = 7'b1111111;
`else
        lead_zero = 7'b1000000;
`endif
        rst_n = 1'b0; load = 1'b0; value = '0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        check("rst_x", {4'd0, x}, 7'b0000111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_ready", {6'd0, ready}, 7'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_x", {4'd0, x}, 7'b0000110);
        check("first_seg", seg, 7'b1000000);
        repeat (11) @(posedge clk);
        #1;
        check("idle_hund_x", {4'd0, x}, 7'b0000011);
        check("idle_hund_seg", seg, lead_zero);

        // 407: ready low for 11 cycles, then digits 4,0,7
        do_load(407);
        low = 0;
        for (int i = 1; i <= 11; i++) begin
            if (!ready) low++;
            @(posedge clk); #1;
        end
        check("ready_low_cycles", 7'(low), 7'd11);
        check("ready_back_c12", {6'd0, ready}, 7'd1);
        wait_x(3'b011); check("d407_hund", seg, 7'b0011001);
        wait_x(3'b101); check("d407_tens", seg, 7'b1000000);
        wait_x(3'b110); check("d407_units", seg, 7'b1111000);

        // 1000: overflow dashes
        do_load(1000);
        repeat (11) @(posedge clk);
        #1;
        check("ovf_ready_c12", {6'd0, ready}, 7'd1);
        wait_x(3'b011); check("ovf_hund", seg, 7'b0111111);
        wait_x(3'b110); check("ovf_units", seg, 7'b0111111);

        // 123 accepted, 999 on cycle 3 ignored
        do_load(123);
        repeat (2) @(posedge clk);
        #1;
        do_load(999);
        repeat (8) @(posedge clk);
        #1;
        check("ign_ready_c12", {6'd0, ready}, 7'd1);
        wait_x(3'b011); check("d123_hund", seg, 7'b1111001);
        wait_x(3'b101); check("d123_tens", seg, 7'b0100100);
        wait_x(3'b110); check("d123_units", seg, 7'b0110000);

        // 555 aborted by reset on cycle 5
        do_load(555);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_x", {4'd0, x}, 7'b0000111);
        check("abort_seg", seg, 7'b1111111);
        check("abort_ready", {6'd0, ready}, 7'd1);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        wait_x(3'b110); check("abort_units", seg, 7'b1000000);
        wait_x(3'b011); check("abort_hund", seg, lead_zero);

        // illegal digit index recovers on the next edge
        chk_en = 0;
        wait_x(3'b101);
        force dut.digit_idx = 2'd3;
        #1;
        release dut.digit_idx;
        @(posedge clk); #1;
        check("idx3_index", {5'd0, dut.digit_idx}, 7'd0);
        check("idx3_x", {4'd0, x}, 7'b0000110);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1;

        // random loads, values biased to boundaries, occasional reset
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom % 6 == 0);
            r = int'($urandom % 8);
            case (r)
                0: value = 10'd999;
                1: value = 10'd1000;
                2: value = 10'd0;
                3: value = 10'd1023;
                default: value = 10'($urandom % 1024);
            endcase
            rst_n = ($urandom % 400 != 0);
            @(posedge clk); #1;
        end
        load = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000: clk cycles per digit scan slot, legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port load  input  1  single-cycle request to capture value.
REQ-005 SHALL have port value  input  10  unsigned binary result from calculator, 0..1023.
REQ-006 SHALL have port ready  output  1  high when converter idle and load will be accepted.
REQ-007 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-008 SHALL have port x  output  3  active-low digit enables, registered; x[0]=units, x[1]=tens, x[2]=hundreds.

Function
REQ-009 SHALL contain a converter FSM with states IDLE, SHIFT, COMMIT; ready=1 only in IDLE.
REQ-010 IDLE: load=1 captures value, clears shift counter, goes to SHIFT; load=0 stays in IDLE.
REQ-011 SHIFT: one double-dabble iteration per cycle (add 3 to any BCD nibble >=5, then shift left 1); after exactly 10 iterations goes to COMMIT.
REQ-012 COMMIT: writes hundreds/tens/units into display registers in one cycle, returns to IDLE.
REQ-013 Latency: display registers hold new digits 12 cycles after the load-accept edge; ready low for cycles 1..11 after accept, high again on cycle 12.
REQ-014 load while ready=0 SHALL be ignored, not queued; in-progress conversion unaffected.
REQ-015 value>999 at capture SHALL set an overflow flag committed with the digits; overflow shows dash (7'b0111111) on all three digits; conversion latency unchanged.
REQ-016 Display registers change only in COMMIT; scanning shows the previous result during conversion.
REQ-017 SHALL contain a prescaler counting 0..PRESCALE-1 and wrapping to 0; on wrap, digit index advances 0->1->2->0.
REQ-018 Digit index 3 SHALL never occur; if reached it SHALL be forced to 0 on the next cycle.
REQ-019 x SHALL be 3'b110, 3'b101, 3'b011 for index 0, 1, 2; exactly one bit low outside reset.
REQ-020 seg SHALL show the digit for the current index, registered in the same cycle as x (no skew); 0..9 encode 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; blank is 1111111.
REQ-021 Scan SHALL run continuously and independently of converter state.
REQ-022 A COMMIT on the same cycle as a prescaler wrap SHALL take effect on the next displayed slot without corrupting the index.

Reset
REQ-023 rst_n=0 at a clk edge: FSM to IDLE, ready=1, prescaler=0, index=0, display digits=0, overflow=0, seg=7'b1111111, x=3'b111.
REQ-024 Reset mid-conversion SHALL abort it; display registers revert to 0, no partial commit.
REQ-025 First edge after rst_n rises: x=3'b110, seg shows units digit 0.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN defined: hundreds blank if 0; tens blank if hundreds and tens both 0; units never blank; overflow dashes unaffected.
REQ-027 Macro LEADING_ZERO_BLANK_EN undefined: all three digits always shown, including leading zeros.

Verification (PRESCALE=4)
REQ-028 Reset release, no load -> x cycles 110,101,011 every 4 clk; seg 1000000 each slot (macro on: hundreds/tens 1111111).
REQ-029 load with value=10'd407 in IDLE -> ready low 11 cycles; display 4,0,7 from cycle 12; tens shows 1000000 in both macro builds.
REQ-030 load with value=10'd1000 -> all digits 0111111 after commit; ready returns after 12 cycles.
REQ-031 load 123, then load 999 on cycle 3 -> second ignored; display 1,2,3.
REQ-032 rst_n low on cycle 5 of conversion of 555 -> x=111, seg=1111111, ready=1; after release display 000, no 5s.
REQ-033 Force digit index to 3 -> index 0 and x=110 on next edge.
